// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: ALU opcode width, the decoded control
// bundle carried down the pipe, the bubble constant and the freeze FSM states.
package cpu_pkg;

    localparam int ALUOP_W = 4;

    typedef logic [ALUOP_W-1:0] aluop_t;

    // Decoded control bits that travel from ID into EX together.
    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        aluop_t aluop;
    } ctrl_t;

    // A bubble carries no side effects: nothing written, nothing read.
    localparam ctrl_t CTRL_NOP = '0;

    // Tracks whether the pipe is currently frozen by a busy data memory.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } freeze_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load sitting in EX whose destination is
// read by the instruction currently in decode. Kept standalone so a later
// branch-in-ID hazard unit can reuse the same compare.
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_lu
);

    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        w_ex_is_load = i_ex_valid && i_ex_memread && (i_ex_rd != 5'd0);
        w_rs_match   = (i_ex_rd == i_id_rs);
        w_rt_match   = i_id_uses_rt && (i_ex_rd == i_id_rt);
        o_lu         = w_ex_is_load && i_id_valid && (w_rs_match || w_rt_match);
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, memory-busy freeze,
// flush handling and saturating bubble/stall performance counters.
module id_ex_hazard_reg #(
    parameter int ALUOP_W = cpu_pkg::ALUOP_W,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rt,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_memtoreg,
    input  logic               id_alusrc,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               flush,
    input  logic               mem_busy,
    output logic               ex_valid,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_rd,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               stall,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    import cpu_pkg::*;

    // EX-stage state
    logic                r_valid;
    logic [4:0]          r_rs;
    logic [4:0]          r_rt;
    logic [4:0]          r_rd;
    ctrl_t               r_ctrl;
    logic [DATA_W-1:0]   r_rdata1;
    logic [DATA_W-1:0]   r_rdata2;
    logic [DATA_W-1:0]   r_imm;

    // Performance counters and freeze tracking
    logic [CNT_W-1:0]    r_bubble_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    freeze_state_t       r_state;

    logic                w_lu;
    logic                w_load_bubble;
    logic                w_stall;
    ctrl_t               w_id_ctrl;

    load_use_detect u_load_use_detect (
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_ctrl.memread),
        .i_ex_rd      (r_rd),
        .i_id_valid   (id_valid),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rt (id_uses_rt),
        .o_lu         (w_lu)
    );

    // Stall and bubble decisions; a flush kills the stalled instruction so it
    // overrides the load-use stall, and a busy memory overrides everything.
    always_comb begin
        w_load_bubble = !mem_busy && (flush || w_lu);
        w_stall       = rst_n && (mem_busy || (w_lu && !flush));
    end

    // Gather decode control into one bundle; an invalid decode looks like a bubble.
    always_comb begin
        w_id_ctrl = CTRL_NOP;
        if (id_valid) begin
            w_id_ctrl.regwrite = id_regwrite;
            w_id_ctrl.memread  = id_memread;
            w_id_ctrl.memwrite = id_memwrite;
            w_id_ctrl.memtoreg = id_memtoreg;
            w_id_ctrl.alusrc   = id_alusrc;
            w_id_ctrl.aluop    = aluop_t'(id_aluop);
        end
    end

    // Pipeline register: reset, hold on busy memory, bubble, or load decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_rs     <= 5'd0;
            r_rt     <= 5'd0;
            r_rd     <= 5'd0;
            r_ctrl   <= CTRL_NOP;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
        end else if (mem_busy) begin
            r_valid  <= r_valid;
        end else if (w_load_bubble) begin
            r_valid  <= 1'b0;
            r_rs     <= 5'd0;
            r_rt     <= 5'd0;
            r_rd     <= 5'd0;
            r_ctrl   <= CTRL_NOP;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
        end else begin
            r_valid  <= id_valid;
            r_rs     <= id_rs;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_ctrl   <= w_id_ctrl;
            r_rdata1 <= id_rdata1;
            r_rdata2 <= id_rdata2;
            r_imm    <= id_imm;
        end
    end

    // Saturating counters: bubbles inserted and cycles spent stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_load_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Freeze tracker: FROZEN while memory is busy, back to RUN when it frees up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:    if (mem_busy)  r_state <= ST_FROZEN;
                ST_FROZEN: if (!mem_busy) r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    assign ex_valid    = r_valid;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_memtoreg = r_ctrl.memtoreg;
    assign ex_alusrc   = r_ctrl.alusrc;
    assign ex_aluop    = ALUOP_W'(r_ctrl.aluop);
    assign ex_rdata1   = r_rdata1;
    assign ex_rdata2   = r_rdata2;
    assign ex_imm      = r_imm;
    assign stall       = w_stall;
    assign bubble_cnt  = r_bubble_cnt;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Testbench for id_ex_hazard_reg: directed hazard/flush/freeze/saturation
// scenarios followed by a random phase, all checked against a cycle model.
module tb_id_ex_hazard_reg;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        rstN;
    logic        idValid;
    logic [4:0]  idRs, idRt, idRd;
    logic        idUsesRt, idRegwrite, idMemread, idMemwrite, idMemtoreg, idAlusrc;
    logic [3:0]  idAluop;
    logic [31:0] idRdata1, idRdata2, idImm;
    logic        flush, memBusy;

    logic        exValid;
    logic [4:0]  exRs, exRt, exRd;
    logic        exRegwrite, exMemread, exMemwrite, exMemtoreg, exAlusrc;
    logic [3:0]  exAluop;
    logic [31:0] exRdata1, exRdata2, exImm;
    logic        stall;
    logic [3:0]  bubbleCnt, stallCnt;

    int checks   = 0;
    int failures = 0;

    // Expected EX contents and counters
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        regwrite, memread, memwrite, memtoreg, alusrc;
        logic [3:0]  aluop;
        logic [31:0] rdata1, rdata2, imm;
    } exModel_t;

    exModel_t mEx;
    int       mBubble;
    int       mStall;

    id_ex_hazard_reg #(.ALUOP_W(4), .DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rstN),
        .id_valid(idValid), .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
        .id_uses_rt(idUsesRt), .id_regwrite(idRegwrite), .id_memread(idMemread),
        .id_memwrite(idMemwrite), .id_memtoreg(idMemtoreg), .id_alusrc(idAlusrc),
        .id_aluop(idAluop), .id_rdata1(idRdata1), .id_rdata2(idRdata2), .id_imm(idImm),
        .flush(flush), .mem_busy(memBusy),
        .ex_valid(exValid), .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd),
        .ex_regwrite(exRegwrite), .ex_memread(exMemread), .ex_memwrite(exMemwrite),
        .ex_memtoreg(exMemtoreg), .ex_alusrc(exAlusrc), .ex_aluop(exAluop),
        .ex_rdata1(exRdata1), .ex_rdata2(exRdata2), .ex_imm(exImm),
        .stall(stall), .bubble_cnt(bubbleCnt), .stall_cnt(stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // A load in EX blocks a decode instruction that reads its destination
    function automatic logic modelLoadUse();
        return mEx.valid && mEx.memread && (mEx.rd != 5'd0) && idValid &&
               ((mEx.rd == idRs) || (idUsesRt && (mEx.rd == idRt)));
    endfunction

    function automatic logic modelStall();
        return rstN && (memBusy || (modelLoadUse() && !flush));
    endfunction

    task automatic modelStep();
        logic lu;
        lu = modelLoadUse();
        if (!rstN) begin
            mEx     = '{default: 0};
            mBubble = 0;
            mStall  = 0;
        end else if (memBusy) begin
            if (mStall < CNT_MAX) mStall++;
        end else if (flush || lu) begin
            mEx = '{default: 0};
            if (mBubble < CNT_MAX) mBubble++;
            if (!flush && mStall < CNT_MAX) mStall++;
        end else begin
            mEx.valid    = idValid;
            mEx.rs       = idRs;
            mEx.rt       = idRt;
            mEx.rd       = idRd;
            mEx.regwrite = idValid & idRegwrite;
            mEx.memread  = idValid & idMemread;
            mEx.memwrite = idValid & idMemwrite;
            mEx.memtoreg = idValid & idMemtoreg;
            mEx.alusrc   = idValid & idAlusrc;
            mEx.aluop    = idValid ? idAluop : 4'd0;
            mEx.rdata1   = idRdata1;
            mEx.rdata2   = idRdata2;
            mEx.imm      = idImm;
        end
    endtask

    // One clock: check stall mid-cycle, advance the model, check EX after the edge
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("stall", stall, modelStall());
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("ex_valid", exValid, mEx.valid);
        checkOutput("ex_rs", exRs, mEx.rs);
        checkOutput("ex_rt", exRt, mEx.rt);
        checkOutput("ex_rd", exRd, mEx.rd);
        checkOutput("ex_regwrite", exRegwrite, mEx.regwrite);
        checkOutput("ex_memread", exMemread, mEx.memread);
        checkOutput("ex_memwrite", exMemwrite, mEx.memwrite);
        checkOutput("ex_memtoreg", exMemtoreg, mEx.memtoreg);
        checkOutput("ex_alusrc", exAlusrc, mEx.alusrc);
        checkOutput("ex_aluop", exAluop, mEx.aluop);
        checkOutput("ex_rdata1", exRdata1, mEx.rdata1);
        checkOutput("ex_rdata2", exRdata2, mEx.rdata2);
        checkOutput("ex_imm", exImm, mEx.imm);
        checkOutput("bubble_cnt", bubbleCnt, mBubble);
        checkOutput("stall_cnt", stallCnt, mStall);
    endtask

    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic usesRt, input logic rw, input logic mr, input logic mw,
                         input logic mt, input logic as, input logic [3:0] op);
        idValid = v; idRs = rs; idRt = rt; idRd = rd; idUsesRt = usesRt;
        idRegwrite = rw; idMemread = mr; idMemwrite = mw; idMemtoreg = mt; idAlusrc = as;
        idAluop = op;
        idRdata1 = $urandom; idRdata2 = $urandom; idImm = $urandom;
    endtask

    task automatic setLoad(input logic [4:0] rd);
        setId(1'b1, 5'd1, 5'd0, rd, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    endtask

    task automatic setAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        setId(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    endtask

    task automatic setRandomId();
        setId($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
              1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    endtask

    task automatic doReset();
        rstN = 1'b0; memBusy = 1'b0; flush = 1'b0;
        applyStimulus();
        rstN = 1'b1;
    endtask

    initial begin
        mEx = '{default: 0}; mBubble = 0; mStall = 0;

        // Reset with random decode inputs, memory busy on the second cycle
        rstN = 1'b0; flush = 1'b0; memBusy = 1'b0;
        setRandomId();
        applyStimulus();
        setRandomId();
        memBusy = 1'b1;
        applyStimulus();
        #1;
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_ex_valid", exValid, 1'b0);
        checkOutput("rst_bubble_cnt", bubbleCnt, 4'd0);
        checkOutput("rst_stall_cnt", stallCnt, 4'd0);
        rstN = 1'b1; memBusy = 1'b0;

        // lw r8 followed by add reading r8
        doReset();
        setLoad(5'd8);
        applyStimulus();
        setAdd(5'd8, 5'd9, 5'd10);
        #1;
        checkOutput("lu_stall", stall, 1'b1);
        applyStimulus();
        checkOutput("lu_bubble_valid", exValid, 1'b0);
        #1;
        checkOutput("lu_stall_once", stall, 1'b0);
        applyStimulus();
        checkOutput("lu_dep_rs", exRs, 5'd8);
        checkOutput("lu_dep_regwrite", exRegwrite, 1'b1);
        checkOutput("lu_bubble_cnt", bubbleCnt, 4'd1);
        checkOutput("lu_stall_cnt", stallCnt, 4'd1);

        // Load to r0 followed by a reader of r0
        doReset();
        setLoad(5'd0);
        applyStimulus();
        setAdd(5'd0, 5'd0, 5'd3);
        #1;
        checkOutput("r0_stall", stall, 1'b0);
        applyStimulus();
        checkOutput("r0_bubble_cnt", bubbleCnt, 4'd0);

        // Store not using rt, rt matching the load destination
        doReset();
        setLoad(5'd8);
        applyStimulus();
        setId(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        #1;
        checkOutput("st_stall", stall, 1'b0);
        applyStimulus();
        checkOutput("st_bubble_cnt", bubbleCnt, 4'd0);

        // Flush together with a load-use hazard
        doReset();
        setLoad(5'd8);
        applyStimulus();
        setAdd(5'd8, 5'd9, 5'd10);
        flush = 1'b1;
        #1;
        checkOutput("fl_stall", stall, 1'b0);
        applyStimulus();
        checkOutput("fl_bubble_valid", exValid, 1'b0);
        checkOutput("fl_stall_cnt", stallCnt, 4'd0);
        flush = 1'b0;
        setAdd(5'd8, 5'd11, 5'd12);
        applyStimulus();
        checkOutput("fl_next_valid", exValid, 1'b1);
        checkOutput("fl_next_rd", exRd, 5'd12);

        // Memory freeze with flush pending
        doReset();
        setAdd(5'd3, 5'd5, 5'd4);
        applyStimulus();
        memBusy = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setRandomId();
            #1;
            checkOutput("mb_stall", stall, 1'b1);
            applyStimulus();
            checkOutput("mb_hold_rs", exRs, 5'd3);
            checkOutput("mb_hold_rd", exRd, 5'd4);
        end
        checkOutput("mb_stall_cnt", stallCnt, 4'd3);
        memBusy = 1'b0;
        applyStimulus();
        checkOutput("mb_release_valid", exValid, 1'b0);
        checkOutput("mb_release_bubble_cnt", bubbleCnt, 4'd1);
        flush = 1'b0;

        // Twenty load-use pairs saturate both counters
        doReset();
        for (int i = 0; i < 20; i++) begin
            setLoad(5'd8);
            applyStimulus();
            setAdd(5'd8, 5'd9, 5'd10);
            applyStimulus();
            applyStimulus();
        end
        checkOutput("sat_bubble_cnt", bubbleCnt, 4'd15);
        checkOutput("sat_stall_cnt", stallCnt, 4'd15);

        // Random traffic against the model
        doReset();
        for (int i = 0; i < 400; i++) begin
            rstN    = ($urandom_range(0, 49) != 0);
            memBusy = ($urandom_range(0, 5) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            setRandomId();
            applyStimulus();
        end

        $display("[TB] run complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
